// File: rtl/memc_collect.sv
// Drain-side collector for the systolic array: de-skews per-row result lanes into a DIM x DIM matrix.
// Define MEMC_TRANSPOSE_EN to make reads return a column of C instead of a row.
module memc_collect #(
    parameter int BITS_C = 16,
    parameter int DIM    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [BITS_C-1:0] Cin  [DIM],
    input  logic                     rd_en,
    input  logic [$clog2(DIM)-1:0]   Crow,
    output logic signed [BITS_C-1:0] Cout [DIM],
    output logic                     busy,
    output logic                     done
);

    localparam int CW = $clog2(2*DIM);
    localparam logic [CW-1:0] CNT_LAST = CW'(2*DIM-2);

    typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            cnt;
    logic signed [BITS_C-1:0] cmat [DIM][DIM];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state != CAPTURE && start)
                cnt <= '0;
            else if (state == CAPTURE)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CAPTURE;
            CAPTURE: if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (start) state_nxt = CAPTURE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CAPTURE);
        done = (state == DONE);
    end

    // Lane r is valid for t in [r, r+DIM); element C[r][t-r] lands where cnt == r + c.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++)
                    cmat[r][c] <= '0;
        end else if (state == CAPTURE) begin
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++)
                    if (int'(cnt) == r + c)
                        cmat[r][c] <= Cin[r];
        end
    end

    // Registered read; non-blocking update of cmat gives read-before-write on a shared edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DIM; j++)
                Cout[j] <= '0;
        end else if (rd_en) begin
            for (int j = 0; j < DIM; j++) begin
`ifdef MEMC_TRANSPOSE_EN
                Cout[j] <= cmat[j][Crow];
`else
                Cout[j] <= cmat[Crow][j];
`endif
            end
        end
    end

endmodule

// File: tb/tb_memc_collect.sv
// Directed bench for memc_collect with a read-data scoreboard; honours MEMC_TRANSPOSE_EN.
module tb_memc_collect;

    localparam int DIM = 8;
    localparam int BW  = 16;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic                 rd_en = 1'b0;
    logic [2:0]           crow = 3'd0;
    logic signed [BW-1:0] cin  [DIM];
    logic signed [BW-1:0] cout [DIM];
    logic                 busy, done;

    logic signed [BW-1:0] refm [DIM][DIM];
    logic signed [BW-1:0] last [DIM];
    logic signed [BW-1:0] exp_q [$];
    int ncmp = 0;
    int nfail = 0;

    memc_collect #(.BITS_C(BW), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .Cin(cin),
        .rd_en(rd_en), .Crow(crow), .Cout(cout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [BW-1:0] val(input int mode, input int r, input int c);
        case (mode)
            0:       return BW'(16*r + c);
            1:       return 16'hFFFF;
            default: return BW'(-(16*r + c));
        endcase
    endfunction

    task automatic push_read(input int row);
        for (int j = 0; j < DIM; j++) begin
`ifdef MEMC_TRANSPOSE_EN
            exp_q.push_back(refm[j][row]);
`else
            exp_q.push_back(refm[row][j]);
`endif
        end
        rd_en = 1'b1;
        crow  = 3'(row);
    endtask

    task automatic pop_check(input string tag);
        logic signed [BW-1:0] e;
        for (int j = 0; j < DIM; j++) begin
            if (exp_q.size() == 0) begin
                check({tag, "_empty"}, 16'h0001, 16'h0000);
            end else begin
                e = exp_q.pop_front();
                check(tag, cout[j], e);
                last[j] = e;
            end
        end
    endtask

    task automatic do_read(input int row);
        @(negedge clk);
        push_read(row);
        @(negedge clk);
        rd_en = 1'b0;
        crow  = 3'(row ^ 5);
        pop_check("read");
        @(negedge clk);
        for (int j = 0; j < DIM; j++) check("hold", cout[j], last[j]);
    endtask

    task automatic run_capture(input int mode, input int restart_at, input int rd_at, input int rst_at);
        @(negedge clk);
        start = 1'b1;
        for (int r = 0; r < DIM; r++) cin[r] = 16'hDEAD;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", 16'(busy), 16'h1);
        check("start_done", 16'(done), 16'h0);
        for (int t = 0; t < 2*DIM-1; t++) begin
            if (t == rst_at) begin
                rst_n = 1'b0;
                #1;
                for (int j = 0; j < DIM; j++) check("rst_cout", cout[j], 16'h0);
                check("rst_busy", 16'(busy), 16'h0);
                check("rst_done", 16'(done), 16'h0);
                for (int r = 0; r < DIM; r++)
                    for (int c = 0; c < DIM; c++) refm[r][c] = '0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            for (int r = 0; r < DIM; r++)
                cin[r] = (t >= r && t < r + DIM) ? val(mode, r, t - r) : 16'hDEAD;
            start = (t == restart_at);
            if (t == rd_at) push_read(7);
            for (int r = 0; r < DIM; r++)
                if (t >= r && t < r + DIM) refm[r][t-r] = val(mode, r, t - r);
            @(negedge clk);
            if (t == rd_at) begin
                rd_en = 1'b0;
                pop_check("cap_read");
            end
            if (t < 2*DIM-2) begin
                check("cap_busy", 16'(busy), 16'h1);
                check("cap_done_early", 16'(done), 16'h0);
            end
        end
        start = 1'b0;
        check("end_busy", 16'(busy), 16'h0);
        check("end_done", 16'(done), 16'h1);
    endtask

    task automatic read_all();
        for (int row = 0; row < DIM; row++) do_read(row);
    endtask

    initial begin
        for (int r = 0; r < DIM; r++) begin
            cin[r] = '0;
            last[r] = '0;
            for (int c = 0; c < DIM; c++) refm[r][c] = '0;
        end

        // Reset state and an empty-matrix read.
        #12;
        for (int j = 0; j < DIM; j++) check("reset_cout", cout[j], 16'h0);
        check("reset_busy", 16'(busy), 16'h0);
        check("reset_done", 16'(done), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_read(3);

        // Full capture with ascending data.
        run_capture(0, -1, -1, -1);
        read_all();

        // A start pulse mid-capture must be ignored.
        run_capture(0, 4, -1, -1);
        read_all();

        // Reset mid-capture, then an all-ones capture.
        run_capture(1, -1, -1, 7);
        do_read(3);
        run_capture(1, -1, -1, -1);
        read_all();

        // Restart from DONE with negated data; read row 7 while it still holds old data.
        run_capture(0, -1, -1, -1);
        run_capture(2, -1, 3, -1);
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/memc_collect.md
# memc_collect

Result-collection buffer on the drain side of the systolic tpumac array, the counterpart to the skewed-column loader on the input side. The array presents one result element per systolic row every cycle, skewed by one cycle per row. This block de-skews that stream into a DIM×DIM register array. It then serves complete, aligned rows of C to the host side on request.

## Interface
- BITS_C, default 16: width of one signed result element.
- DIM, default 8: array dimension (rows = columns = lanes).
- clk  in  1: clock, rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- start  in  1: begin a capture; sampled on a rising edge.
- Cin  in  signed [BITS_C-1:0] × DIM: lane r carries the output of systolic row r.
- rd_en  in  1: read request.
- Crow  in  [$clog2(DIM)-1:0]: read index.
- Cout  out  signed [BITS_C-1:0] × DIM: registered read data.
- busy  out  1: high while in CAPTURE.
- done  out  1: high while in DONE (full matrix held).

## Operation
- States:
  - IDLE: reset state.
  - CAPTURE.
  - DONE.
- Capture counter cnt has width $clog2(2*DIM).
- IDLE or DONE with start=1 at an edge:
  - state <= CAPTURE, cnt <= 0.
  - Stored matrix is not cleared, unless the Configuration feature applies.
- CAPTURE, at each edge, with t = cnt:
  - For every lane r with r ≤ t < r+DIM, store Cin[r] into C[r][t-r].
  - Lanes outside that window are ignored.
  - cnt <= cnt+1.
- CAPTURE with cnt == 2*DIM-2 at an edge: final sample taken, state <= DONE.
- start while in CAPTURE is ignored; no restart.
- DONE holds until the next start, which re-enters CAPTURE directly.
- Read, rd_en=1 at an edge: Cout <= C[Crow][0..DIM-1], lane j = column j.
  - rd_en=0: Cout holds its value.
  - Reads are legal in every state. During CAPTURE they return current contents: a mix of new and old elements.
  - Read and capture on the same edge return pre-edge contents (read-before-write).
- No arithmetic is performed; elements are stored bit-exact with no width change.

## Timing
- Reset values: state IDLE, cnt 0, every C element 0, Cout all 0, busy 0, done 0.
- start high at edge k:
  - busy=1 after edge k.
  - Lane samples are taken at edges k+1 … k+2*DIM-1.
  - busy=0 and done=1 after edge k+2*DIM-1.
- For DIM=8, capture takes 15 cycles.
- start in DONE at edge m: done=0 and busy=1 after edge m.
- Read latency: 1 cycle. Crow is sampled with rd_en at edge n, and data is valid after edge n.
- rst_n low at any time, including mid-capture:
  - All state and outputs return to reset values immediately.
  - The partial matrix is discarded.
  - The first start after deassertion behaves as from IDLE.

## Configuration
- MEMC_TRANSPOSE_EN defined:
  - A read returns column Crow.
  - Lane j of Cout = C[j][Crow].
- MEMC_TRANSPOSE_EN undefined:
  - A read returns row Crow.
  - Lane j of Cout = C[Crow][j].
- Capture, state machine and timing are identical in both builds.

## Test plan
- Reset: rst_n low → Cout all 0, busy=0, done=0. With no start, read Crow=3 → all 0.
- Full capture, DIM=8, BITS_C=16:
  - start, then drive lane r = 16*r + (t-r) inside its window and 16'hDEAD outside it.
  - Expect done exactly 15 cycles after start.
  - Read Crow=5 → lanes 80…87; no 16'hDEAD anywhere.
- Busy start: pulse start again at capture cycle 4 → ignored; done still asserts at cycle 15 and data is unaffected.
- Mid-capture reset: assert rst_n low at capture cycle 7 → all outputs 0.
  - A new capture of all-ones data then reads back 16'hFFFF on every lane.
- Restart from DONE:
  - Second capture with data = -(16*r + c).
  - During capture, read Crow=7 at t=3 → old row 7 values.
  - After done, Crow=7 → -112…-119.
- MEMC_TRANSPOSE_EN build: same data as the full-capture test; read Crow=2 → lane j = 16*j+2.
